imem_boot_loader: RTL and testbench

- Boot-time sequencer for the single-issue core.
- Holds the core in reset, accepts a framed program image over a valid/ready word stream, and writes it into instruction memory from word 0.
- Verifies an additive checksum and releases the core's reset only on a good image. Flags an error otherwise.
- Sits between the host/debug link and the core plus its instruction memory.

---
 rtl/imem_boot_loader.sv | 112 +++++++++++
 tb/tb_imem_boot_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot-time loader: holds the core in reset, streams a framed image into instruction memory,
// and releases the core only when the additive checksum matches.
module imem_boot_loader #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {StIdle, StHdr, StData, StCsum, StRun, StErr} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic [31:0]         sum_q, sum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                xfer;
  logic [ADDR_W:0]     wl_inc;

  assign busy    = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);
  assign s_ready = busy;
  assign xfer    = s_valid && s_ready;
  assign wl_inc  = wl_q + (ADDR_W + 1)'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wl_d    = wl_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // A new request wins over any same-cycle word, which is dropped.
    if (load_req) begin
      state_d = StHdr;
      wl_d    = '0;
      sum_d   = '0;
    end else begin
      unique case (state_q)
        StHdr: begin
          if (xfer) begin
            if (s_data == 32'd0 || s_data > 32'(MEM_WORDS)) begin
              state_d = StErr;
            end else begin
              count_d = s_data[ADDR_W:0];
              sum_d   = '0;
              wl_d    = '0;
              state_d = StData;
            end
          end
        end
        StData: begin
          if (xfer) begin
            we_d    = 1'b1;
            addr_d  = wl_q[ADDR_W-1:0];
            wdata_d = s_data;
            wl_d    = wl_inc;
            sum_d   = sum_q + s_data;
            if (wl_inc == count_q) state_d = StCsum;
          end
        end
        StCsum: begin
          if (xfer) state_d = (s_data == sum_q) ? StRun : StErr;
        end
        StIdle, StRun, StErr: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      wl_q    <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wl_q    <= wl_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst_n    = (state_q == StRun);
  assign error        = (state_q == StErr);
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frame table with a session-level model of expected writes and
// outcome, plus hand-written abort and mid-session reset sequences.
module tb_imem_boot_loader;
  localparam int unsigned MEM_WORDS = 4096;
  localparam int unsigned ADDR_W    = 12;

  logic              clk, rst_n, load_req, s_valid, s_ready;
  logic [31:0]       s_data;
  logic              imem_we, cpu_rst_n, busy, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .error(error), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {logic [ADDR_W-1:0] a; logic [31:0] d;} wr_t;
  wr_t               exp_q[$];
  int                wr_cyc[$];
  logic [ADDR_W-1:0] last_wr_addr;

  always @(posedge clk) cyc <= cyc + 1;

  // Every observed write must match the next one the model predicted.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_t e;
      check("write_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.a));
        check("wr_data", imem_wdata, e.d);
      end
      wr_cyc.push_back(cyc);
      last_wr_addr <= imem_addr;
    end
  end

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int bubble_pct);
    int t = 0;
    while (int'($urandom_range(99)) < bubble_pct) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_timeout", 32'(t < 100), 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  typedef struct {
    int unsigned n;
    bit          good;
    bit          fixed;
    int          bubble;
    bit          exp_run;
    int unsigned exp_wl;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] words[$];
    logic [31:0] csum;
    logic [31:0] w0, w1;
    bit          hdr_ok;

    rst_n = 1'b0; load_req = 1'b0; s_valid = 1'b0; s_data = '0;
    #3;
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("rst_imem_we", 32'(imem_we), 0);
    check("rst_imem_addr", 32'(imem_addr), 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_error", 32'(error), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_words_loaded", 32'(words_loaded), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_cpu_rst_n", 32'(cpu_rst_n), 0);

    tbl[0] = '{n: 3, good: 1, fixed: 1, bubble: 0, exp_run: 1, exp_wl: 3};
    tbl[1] = '{n: 3, good: 0, fixed: 1, bubble: 0, exp_run: 0, exp_wl: 3};
    tbl[2] = '{n: 3, good: 1, fixed: 1, bubble: 0, exp_run: 1, exp_wl: 3};
    tbl[3] = '{n: 0, good: 1, fixed: 0, bubble: 0, exp_run: 0, exp_wl: 0};
    tbl[4] = '{n: MEM_WORDS + 1, good: 1, fixed: 0, bubble: 0, exp_run: 0, exp_wl: 0};
    tbl[5] = '{n: 1, good: 1, fixed: 0, bubble: 20, exp_run: 1, exp_wl: 1};
    tbl[6] = '{n: 7, good: 0, fixed: 0, bubble: 50, exp_run: 0, exp_wl: 7};
    tbl[7] = '{n: MEM_WORDS, good: 1, fixed: 0, bubble: 30, exp_run: 1, exp_wl: MEM_WORDS};

    for (int v = 0; v < 8; v++) begin
      words.delete();
      wr_cyc.delete();
      if (tbl[v].fixed) begin
        words.push_back(32'h0000_0013);
        words.push_back(32'h0010_0093);
        words.push_back(32'h0020_8113);
      end else begin
        for (int i = 0; i < int'(tbl[v].n) && tbl[v].n <= MEM_WORDS; i++)
          words.push_back($urandom);
      end
      csum = '0;
      foreach (words[i]) csum += words[i];
      // Wrapped sum of the fixed image is 0x003081B9; 0x0030821E is a known-bad checksum.
      if (!tbl[v].good) csum = tbl[v].fixed ? 32'h0030_821E : csum + 32'd1;
      hdr_ok = (tbl[v].n != 0) && (tbl[v].n <= MEM_WORDS);

      pulse_load();
      check("req_busy", 32'(busy), 1);
      check("req_error", 32'(error), 0);
      check("req_cpu_rst_n", 32'(cpu_rst_n), 0);
      send_word(tbl[v].n, tbl[v].bubble);
      if (hdr_ok) begin
        foreach (words[i]) exp_q.push_back('{a: ADDR_W'(i), d: words[i]});
        foreach (words[i]) send_word(words[i], tbl[v].bubble);
        check("pre_csum_cpu_rst_n", 32'(cpu_rst_n), 0);
        send_word(csum, tbl[v].bubble);
      end
      check($sformatf("v%0d_cpu_rst_n", v), 32'(cpu_rst_n), 32'(tbl[v].exp_run));
      check($sformatf("v%0d_error", v), 32'(error), 32'(!tbl[v].exp_run));
      check($sformatf("v%0d_busy", v), 32'(busy), 0);
      check($sformatf("v%0d_words_loaded", v), 32'(words_loaded), tbl[v].exp_wl);
      check($sformatf("v%0d_writes_done", v), 32'(exp_q.size()), 0);
      check($sformatf("v%0d_write_count", v), 32'(wr_cyc.size()), 32'(words.size()));
      if (v == 0 && wr_cyc.size() == 3) check("b2b_write_cycles", 32'(wr_cyc[2] - wr_cyc[0]), 2);
      if (v == 7) check("last_wr_addr", 32'(last_wr_addr), MEM_WORDS - 1);
    end

    // Abort on the second DATA transfer of a 4-word frame.
    w0 = $urandom; w1 = $urandom;
    pulse_load();
    send_word(32'd4, 0);
    exp_q.push_back('{a: '0, d: w0});
    send_word(w0, 0);
    s_valid = 1'b1; s_data = w1; load_req = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; load_req = 1'b0;
    check("abort_busy", 32'(busy), 1);
    check("abort_words_loaded", 32'(words_loaded), 0);
    @(negedge clk);
    check("abort_no_write", 32'(imem_we), 0);
    @(posedge clk); #1;
    w0 = $urandom; w1 = $urandom;
    exp_q.push_back('{a: 0, d: w0});
    exp_q.push_back('{a: 1, d: w1});
    send_word(32'd2, 0);
    send_word(w0, 0);
    send_word(w1, 0);
    send_word(w0 + w1, 0);
    check("abort_new_cpu_rst_n", 32'(cpu_rst_n), 1);
    check("abort_new_words_loaded", 32'(words_loaded), 2);
    check("abort_writes_done", 32'(exp_q.size()), 0);

    // From RUN: re-request, then reset in the middle of DATA.
    pulse_load();
    check("run_req_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("run_req_busy", 32'(busy), 1);
    send_word(32'd4, 0);
    exp_q.push_back('{a: 0, d: w1});
    exp_q.push_back('{a: 1, d: w0});
    send_word(w1, 0);
    send_word(w0, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_imem_we", 32'(imem_we), 0);
    check("mid_rst_s_ready", 32'(s_ready), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("mid_rst_words_loaded", 32'(words_loaded), 0);
    s_valid = 1'b1; s_data = $urandom;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("post_rst_writes", 32'(exp_q.size()), 0);
    check("post_rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("post_rst_s_ready", 32'(s_ready), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
